// File: rtl/angle_vec_pkg.sv
// angle_vec_pkg: shared state type and table math for angle_vector_gen.
// Quarter-wave entries are elaborated from real-valued sine at build time.
package angle_vec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MUL    = 2'd2
  } avg_state_e;

  localparam real PI = 3.14159265358979323846;

  function automatic int ang_width(int steps);
    return $clog2(steps);
  endfunction

  function automatic int quarter_entries(int steps);
    return steps / 4 + 1;
  endfunction

  function automatic int quarter_entry(
    int k,
    int steps,
    int amp_w
  );
    real amp;
    real x;
    amp = real'(2 ** (amp_w - 1));
    x   = amp * $sin(2.0 * PI * real'(k) / real'(steps));
    return $rtoi(x + 0.5);
  endfunction

endpackage

// File: rtl/angle_vector_gen_rom.sv
// quarter_sine_rom: combinational first-quadrant sine magnitude table.
// Index 0..ANGLE_STEPS/4 maps to round(AMP*sin(2*pi*idx/ANGLE_STEPS)).
module quarter_sine_rom
  import angle_vec_pkg::*;
#(
  parameter int ANGLE_STEPS = 64,
  parameter int AMP_W       = 5,
  localparam int IW         = ang_width(ANGLE_STEPS) - 1
) (
  input  logic [IW-1:0]    idx,
  output logic [AMP_W-1:0] mag
);

  localparam int Q     = quarter_entries(ANGLE_STEPS);
  localparam int DEPTH = 2 ** IW;
  localparam int TW    = DEPTH * AMP_W;

  function automatic logic [TW-1:0] build_tab();
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < Q; k++) begin
      t[k*AMP_W +: AMP_W] =
        AMP_W'(quarter_entry(k, ANGLE_STEPS, AMP_W));
    end
    return t;
  endfunction

  localparam logic [TW-1:0] TAB = build_tab();

  // Table read; padding slots past the quarter are zero and never addressed
  always_comb begin
    mag = TAB[int'(idx)*AMP_W +: AMP_W];
  end

endmodule

// File: rtl/angle_vector_gen.sv
// angle_vector_gen: heading + speed -> signed per-frame dx/dy.
// Optional `ANGVEC_TURN_EN adds an internal turnable heading register.
module angle_vector_gen
  import angle_vec_pkg::*;
#(
  parameter int ANGLE_STEPS = 64,
  parameter int AMP_W       = 5,
  parameter int SPEED_W     = 4,
  parameter int OUT_W       = 10,
  localparam int ANG_W      = ang_width(ANGLE_STEPS)
) (
  input  logic               Clk,
  input  logic               Reset_n,
`ifdef ANGVEC_TURN_EN
  input  logic               turn_ccw,
  input  logic               turn_cw,
  output logic [ANG_W-1:0]   heading_o,
`endif
  input  logic               start,
  input  logic [ANG_W-1:0]   angle_i,
  input  logic [SPEED_W-1:0] speed_i,
  output logic               busy,
  output logic               done,
  output logic [OUT_W-1:0]   dx,
  output logic [OUT_W-1:0]   dy
);

  localparam int IW = ANG_W - 1;
  localparam int PW = AMP_W + SPEED_W;
  localparam int BW = (SPEED_W > 1) ? $clog2(SPEED_W) : 1;
  localparam int M  = ANGLE_STEPS / 4;

  localparam logic [BW-1:0] LAST_BIT = BW'(SPEED_W - 1);

  if (OUT_W < AMP_W + SPEED_W + 1) begin : g_out_w_chk
    $error("angle_vector_gen: OUT_W < AMP_W+SPEED_W+1");
  end

  if (ANGLE_STEPS < 8 ||
      (ANGLE_STEPS & (ANGLE_STEPS - 1)) != 0) begin : g_steps_chk
    $error("angle_vector_gen: ANGLE_STEPS not pow2 >= 8");
  end

  avg_state_e state_q, state_d;

  logic [ANG_W-1:0]   ang_q, ang_d;
  logic [SPEED_W-1:0] spd_q, spd_d;
  logic [AMP_W-1:0]   cmag_q, cmag_d;
  logic [AMP_W-1:0]   smag_q, smag_d;
  logic               xneg_q, xneg_d;
  logic               yneg_q, yneg_d;
  logic [PW-1:0]      accx_q, accx_d;
  logic [PW-1:0]      accy_q, accy_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic               done_q, done_d;
  logic [OUT_W-1:0]   dx_q, dx_d;
  logic [OUT_W-1:0]   dy_q, dy_d;

  logic [ANG_W-1:0]   cap_ang;

`ifdef ANGVEC_TURN_EN
  logic [ANG_W-1:0] heading_q, heading_d;
  logic             unused_angle;

  assign unused_angle = ^angle_i;
  assign cap_ang      = heading_q;
  assign heading_o    = heading_q;

  // Heading steps by one per cycle; opposing requests cancel
  always_comb begin
    heading_d = heading_q;
    unique case (1'b1)
      (turn_ccw && !turn_cw): heading_d = heading_q + 1'b1;
      (turn_cw && !turn_ccw): heading_d = heading_q - 1'b1;
      default:                heading_d = heading_q;
    endcase
  end

  // Heading register, free-running in every FSM state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      heading_q <= '0;
    end else begin
      heading_q <= heading_d;
    end
  end
`else
  assign cap_ang = angle_i;
`endif

  logic [1:0]       quad;
  logic [IW-1:0]    rem;
  logic [IW-1:0]    sin_idx;
  logic [IW-1:0]    cos_idx;
  logic [AMP_W-1:0] sin_mag;
  logic [AMP_W-1:0] cos_mag;

  // Fold the captured heading into first-quadrant table indices
  always_comb begin
    quad    = ang_q[ANG_W-1 -: 2];
    rem     = IW'(ang_q[ANG_W-3:0]);
    sin_idx = quad[0] ? IW'(M) - rem : rem;
    cos_idx = quad[0] ? rem : IW'(M) - rem;
  end

  quarter_sine_rom #(
    .ANGLE_STEPS (ANGLE_STEPS),
    .AMP_W       (AMP_W)
  ) u_sin_rom (
    .idx (sin_idx),
    .mag (sin_mag)
  );

  quarter_sine_rom #(
    .ANGLE_STEPS (ANGLE_STEPS),
    .AMP_W       (AMP_W)
  ) u_cos_rom (
    .idx (cos_idx),
    .mag (cos_mag)
  );

  logic [PW-1:0]    addx, addy;
  logic [PW-1:0]    accx_nx, accy_nx;
  logic [OUT_W-1:0] magx, magy;

  // One shift-add step for both products, LSB of speed first
  always_comb begin
    addx    = spd_q[bit_q] ? (PW'(cmag_q) << bit_q) : '0;
    addy    = spd_q[bit_q] ? (PW'(smag_q) << bit_q) : '0;
    accx_nx = accx_q + addx;
    accy_nx = accy_q + addy;
    magx    = OUT_W'(accx_nx);
    magy    = OUT_W'(accy_nx);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    ang_d   = ang_q;
    spd_d   = spd_q;
    cmag_d  = cmag_q;
    smag_d  = smag_q;
    xneg_d  = xneg_q;
    yneg_d  = yneg_q;
    accx_d  = accx_q;
    accy_d  = accy_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    dx_d    = dx_q;
    dy_d    = dy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ang_d   = cap_ang;
          spd_d   = speed_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        cmag_d  = cos_mag;
        smag_d  = sin_mag;
        xneg_d  = quad[1] ^ quad[0];
        yneg_d  = ~quad[1];
        accx_d  = '0;
        accy_d  = '0;
        bit_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        accx_d = accx_nx;
        accy_d = accy_nx;
        bit_d  = bit_q + 1'b1;
        if (bit_q == LAST_BIT) begin
          dx_d    = xneg_q ? -magx : magx;
          dy_d    = yneg_q ? -magy : magy;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ang_q   <= '0;
      spd_q   <= '0;
      cmag_q  <= '0;
      smag_q  <= '0;
      xneg_q  <= 1'b0;
      yneg_q  <= 1'b0;
      accx_q  <= '0;
      accy_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      state_q <= state_d;
      ang_q   <= ang_d;
      spd_q   <= spd_d;
      cmag_q  <= cmag_d;
      smag_q  <= smag_d;
      xneg_q  <= xneg_d;
      yneg_q  <= yneg_d;
      accx_q  <= accx_d;
      accy_q  <= accy_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign dx   = dx_q;
  assign dy   = dy_q;

endmodule

// File: tb/tb_angle_vector_gen.sv
// tb_angle_vector_gen: directed + random scoreboard bench.
// Handles both the default build and ANGVEC_TURN_EN.
module tb_angle_vector_gen;

  localparam int N       = 64;
  localparam int SPEED_W = 4;
  localparam int LAT     = SPEED_W + 2;

  logic       Clk     = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start   = 1'b0;
  logic [5:0] angle_i = '0;
  logic [3:0] speed_i = '0;
  logic       busy;
  logic       done;
  logic [9:0] dx;
  logic [9:0] dy;
`ifdef ANGVEC_TURN_EN
  logic       turn_ccw = 1'b0;
  logic       turn_cw  = 1'b0;
  logic [5:0] heading_o;
`endif

  typedef struct {
    int dx;
    int dy;
  } res_t;

  res_t sb[$];
  res_t mon_e;
  res_t mdl;
  int   tests    = 0;
  int   fails    = 0;
  int   done_cnt = 0;
  int   hdg      = 0;
  int   dc;

  always #5 Clk = ~Clk;

  angle_vector_gen dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
`ifdef ANGVEC_TURN_EN
    .turn_ccw  (turn_ccw),
    .turn_cw   (turn_cw),
    .heading_o (heading_o),
`endif
    .start     (start),
    .angle_i   (angle_i),
    .speed_i   (speed_i),
    .busy      (busy),
    .done      (done),
    .dx        (dx),
    .dy        (dy)
  );

  task automatic check(
    input string tag,
    input int    obs,
    input int    exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  function automatic res_t model(int a, int s);
    res_t r;
    real  th;
    th   = 2.0 * 3.14159265358979 * real'(a) / real'(N);
    r.dx = s * rnd(16.0 * $cos(th));
    r.dy = -s * rnd(16.0 * $sin(th));
    return r;
  endfunction

  always @(negedge Clk) begin
    if (Reset_n && done) begin
      done_cnt++;
      check("busy_in_done", int'(busy), 0);
      if (sb.size() == 0) begin
        check("unexpected_done", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check("dx", int'($signed(dx)), mon_e.dx);
        check("dy", int'($signed(dy)), mon_e.dy);
      end
    end
  end

  task automatic set_angle(input int a);
`ifdef ANGVEC_TURN_EN
    int n;
    n = (a - hdg + N) % N;
    if (n > 0) begin
      turn_ccw = 1'b1;
      repeat (n) begin
        @(posedge Clk);
        #1;
      end
      turn_ccw = 1'b0;
    end
    hdg = a;
`else
    angle_i = 6'(a);
`endif
  endtask

  task automatic issue(
    input int a,
    input int s,
    input int edx,
    input int edy
  );
    res_t e;
    set_angle(a);
    speed_i = 4'(s);
    e.dx = edx;
    e.dy = edy;
    sb.push_back(e);
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    int bcnt;
    lat  = -1;
    bcnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_busy"}, bcnt, LAT - 1);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    repeat (3) step();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_dx", int'($signed(dx)), 0);
    check("rst_dy", int'($signed(dy)), 0);
    Reset_n = 1'b1;
    step();

`ifdef ANGVEC_TURN_EN
    check("rst_heading", int'(heading_o), 0);
    turn_cw = 1'b1;
    step();
    turn_cw = 1'b0;
    check("cw_wrap", int'(heading_o), 63);
    turn_ccw = 1'b1;
    repeat (65) step();
    turn_ccw = 1'b0;
    check("ccw_wrap", int'(heading_o), 0);
    hdg = 0;
    turn_ccw = 1'b1;
    turn_cw  = 1'b1;
    repeat (4) step();
    turn_ccw = 1'b0;
    turn_cw  = 1'b0;
    check("both_hold", int'(heading_o), 0);
    issue(16, 1, 0, -16);
    check("heading16", int'(heading_o), 16);
    wait_done("turn16");
    step();
`endif

    issue(0, 3, 48, 0);
    wait_done("a0s3");
    step();
    issue(8, 2, 22, -22);
    wait_done("a8s2");
    step();
    issue(40, 1, -11, 11);
    wait_done("a40s1");
    step();
    issue(16, 5, 0, -80);
    wait_done("a16s5");
    step();
    issue(32, 15, -240, 0);
    wait_done("a32s15");
    step();
    issue(48, 15, 0, 240);
    wait_done("a48s15");
    step();
    issue(24, 0, 0, 0);
    wait_done("speed0");
    step();

    set_angle(0);
    speed_i = 4'd3;
    mdl.dx = 48;
    mdl.dy = 0;
    sb.push_back(mdl);
    dc = done_cnt;
    start = 1'b1;
    step();
    angle_i = 6'd16;
    speed_i = 4'd15;
`ifdef ANGVEC_TURN_EN
    turn_ccw = 1'b1;
`endif
    repeat (3) step();
    start = 1'b0;
`ifdef ANGVEC_TURN_EN
    turn_ccw = 1'b0;
    hdg = (hdg + 3) % N;
`endif
    repeat (10) step();
    check("held_one_done", done_cnt - dc, 1);

    issue(8, 2, 22, -22);
    wait_done("b2b_first");
    issue(8, 1, 11, -11);
    wait_done("b2b_second");
    step();

    set_angle(32);
    speed_i = 4'd15;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("pre_rst_busy", int'(busy), 1);
    dc = done_cnt;
    Reset_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_dx", int'($signed(dx)), 0);
    check("mid_rst_dy", int'($signed(dy)), 0);
    step();
    Reset_n = 1'b1;
`ifdef ANGVEC_TURN_EN
    hdg = 0;
`endif
    repeat (10) step();
    check("rst_no_done", done_cnt - dc, 0);

    mdl = model(4, 7);
    issue(4, 7, mdl.dx, mdl.dy);
    wait_done("post_rst");
    step();

    for (int i = 0; i < 8; i++) begin
      int a;
      int s;
      a   = $urandom_range(0, N - 1);
      s   = $urandom_range(0, 15);
      mdl = model(a, s);
      issue(a, s, mdl.dx, mdl.dy);
      wait_done("rnd");
      step();
    end

    repeat (4) step();
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
